axi_lite_sram_slave: RTL
========================

Name: axi_lite_sram_slave

Overview:
Synthesizable, parametrised AXI4-Lite slave memory. It replaces the vendor block-memory IP as the instruction/data memory behind the core and the AXI master wrapper. Compared with the fixed-size IP it adds:
- configurable depth, data width and base address;
- programmable read latency;
- byte strobes;
- SLVERR on out-of-range accesses;
- independent AW/W acceptance.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, data width; legal values 32 or 64
STRB_WIDTH, DATA_WIDTH/8, write strobe width
PROT_WIDTH, 3, AxPROT width (ignored)
RESP_WIDTH, 2, xRESP width
DEPTH, 1024, number of DATA_WIDTH words
BASE_ADDR, 32'h0000_0000, byte address of word 0
READ_LATENCY, 1, cycles from AR handshake to rvalid; legal range 1..4

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  reset; asynchronous, active-high
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awprot  in  PROT_WIDTH  ignored
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  STRB_WIDTH  byte enables
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bresp  out  RESP_WIDTH  write response
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arprot  in  PROT_WIDTH  ignored
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  RESP_WIDTH  read response
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready

Behaviour:
- Reset:
  - All outputs are registered and cleared to 0 while areset=1: all readies, bvalid, rvalid, bresp, rresp, rdata.
  - Memory array is not reset.
  - Reset asserted mid-transaction aborts it; no partial write is committed.
- Addressing:
  - word index = (addr - BASE_ADDR) >> log2(STRB_WIDTH); low address bits are ignored.
  - In range iff addr >= BASE_ADDR and index < DEPTH. Otherwise the access is an error: resp = 2'b10 (SLVERR), no write, rdata = 0. OKAY = 2'b00.
- Write FSM, states W_IDLE, W_GOT_A, W_GOT_D, W_COMMIT, W_RESP:
  - W_IDLE: awready=wready=1.
    - AW and W handshake in the same cycle -> W_COMMIT.
    - AW only -> W_GOT_A (awready drops; wready stays 1).
    - W only -> W_GOT_D (wready drops; awready stays 1).
  - W_GOT_A / W_GOT_D: on the missing handshake -> W_COMMIT.
  - W_COMMIT (exactly 1 cycle, both readies 0):
    - Array bytes with wstrb[i]=1 are updated; other bytes are unchanged.
    - wstrb=0 is legal and writes nothing (OKAY).
    - Then bvalid=1, bresp set -> W_RESP.
  - W_RESP: hold bvalid/bresp stable until bready. On the bvalid&bready cycle -> W_IDLE; readies reassert the next cycle.
  - Peak throughput: one write per 3 cycles.
- Read path, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: arready=1. On the AR handshake, the array word is sampled that same cycle (read-before-write against a concurrent W_COMMIT to the same word). Go to R_WAIT with counter = READ_LATENCY-1.
  - R_WAIT: arready=0; counter decrements each cycle. At 0 -> R_RESP. With READ_LATENCY=1, R_WAIT is skipped: rvalid rises the cycle after the AR handshake.
  - R_RESP: rvalid=1; rdata/rresp held stable until rready. On the handshake -> R_IDLE.
  - Only one outstanding read.
- Read and write paths are fully independent and may overlap in any combination.
- A read issued the cycle after a W_COMMIT returns the new data.
- No combinational path from any input to any output.

Test Plan:
1. Reset, then AW+W in the same cycle: addr 0x10, data 0xDEADBEEF, strb 4'hF. Expect bvalid 2 cycles later with bresp=0. Then read 0x10 with READ_LATENCY=1: rvalid the cycle after AR, rdata=0xDEADBEEF, rresp=0.
2. W 5 cycles before AW: data 0x11223344, strb 4'b0101 to a word holding 0xAABBCCDD. Expect awready held 1 and wready=0 while waiting. Readback = 0xAA22CC44.
3. Out-of-range: write to BASE_ADDR+4*DEPTH. Expect bresp=2'b10 and memory unchanged. Read the same address: rresp=2'b10, rdata=0.
4. READ_LATENCY=4, rready held 0 for 3 cycles. Expect rvalid 4 cycles after AR, rdata stable throughout, arready=0 until the cycle after the R handshake.
5. Concurrent: AR to 0x20 (old value 0x1) in the same cycle as W_COMMIT of 0x2 to 0x20. Expect the read to return 0x1; the next read returns 0x2.
6. Assert areset during W_GOT_A. Expect all outputs 0 asynchronously, no write committed, and AW/W readies = 1 the first cycle after release.

Source files
------------

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite slave backed by a byte-maskable word array with independent AW/W
// acceptance, programmable read latency and SLVERR on out-of-range addresses.
module axi_lite_sram_slave #(
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    STRB_WIDTH   = DATA_WIDTH/8,
   parameter int                    PROT_WIDTH   = 3,
   parameter int                    RESP_WIDTH   = 2,
   parameter int                    DEPTH        = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_0000,
   parameter int                    READ_LATENCY = 1
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [PROT_WIDTH-1:0] s_axi_awprot,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [DATA_WIDTH-1:0] s_axi_wdata,
   input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [RESP_WIDTH-1:0] s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [PROT_WIDTH-1:0] s_axi_arprot,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [DATA_WIDTH-1:0] s_axi_rdata,
   output logic [RESP_WIDTH-1:0] s_axi_rresp,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready
);

   localparam int SHIFT = $clog2(STRB_WIDTH);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(2'b00);
   localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2'b10);

   typedef enum logic [2:0] {W_IDLE, W_GOT_A, W_GOT_D, W_COMMIT, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;

   function automatic logic [ADDR_WIDTH-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
      return (a - BASE_ADDR) >> SHIFT;
   endfunction

   function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
      return (a >= BASE_ADDR) && (word_of(a) < ADDR_WIDTH'(DEPTH));
   endfunction

   function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_WIDTH-1:0] a);
      return IDX_W'(word_of(a));
   endfunction

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   wstate_t               wstate_q, wstate_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
   logic                  awready_q, awready_d;
   logic                  wready_q, wready_d;
   logic                  bvalid_q, bvalid_d;
   logic [RESP_WIDTH-1:0] bresp_q, bresp_d;

   rstate_t               rstate_q, rstate_d;
   logic [2:0]            rcnt_q, rcnt_d;
   logic                  arready_q, arready_d;
   logic                  rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [RESP_WIDTH-1:0] rresp_q, rresp_d;

   logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
   logic aw_ok_s, ar_ok_s;
   logic [IDX_W-1:0] aw_idx_s, ar_idx_s;
   logic unused_prot_s;

   assign aw_hs_s  = awready_q & s_axi_awvalid;
   assign w_hs_s   = wready_q & s_axi_wvalid;
   assign b_hs_s   = bvalid_q & s_axi_bready;
   assign ar_hs_s  = arready_q & s_axi_arvalid;
   assign r_hs_s   = rvalid_q & s_axi_rready;
   assign aw_ok_s  = addr_ok(awaddr_q);
   assign aw_idx_s = idx_of(awaddr_q);
   assign ar_ok_s  = addr_ok(s_axi_araddr);
   assign ar_idx_s = idx_of(s_axi_araddr);
   assign unused_prot_s = ^{s_axi_awprot, s_axi_arprot};

   // Write channel next-state: AW and W are captured independently, then committed once.
   always_comb begin
      wstate_d = wstate_q;
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
      if (aw_hs_s) begin
         awaddr_d = s_axi_awaddr;
      end else begin
         awaddr_d = awaddr_q;
      end
      if (w_hs_s) begin
         wdata_d = s_axi_wdata;
         wstrb_d = s_axi_wstrb;
      end else begin
         wdata_d = wdata_q;
         wstrb_d = wstrb_q;
      end
      case (wstate_q)
         W_IDLE: begin
            if (aw_hs_s && w_hs_s) begin
               wstate_d = W_COMMIT;
            end else if (aw_hs_s) begin
               wstate_d = W_GOT_A;
            end else if (w_hs_s) begin
               wstate_d = W_GOT_D;
            end else begin
               wstate_d = W_IDLE;
            end
         end
         W_GOT_A: begin
            if (w_hs_s) begin
               wstate_d = W_COMMIT;
            end else begin
               wstate_d = W_GOT_A;
            end
         end
         W_GOT_D: begin
            if (aw_hs_s) begin
               wstate_d = W_COMMIT;
            end else begin
               wstate_d = W_GOT_D;
            end
         end
         W_COMMIT: begin
            wstate_d = W_RESP;
            bvalid_d = 1'b1;
            bresp_d  = aw_ok_s ? RESP_OKAY : RESP_SLVERR;
         end
         W_RESP: begin
            if (b_hs_s) begin
               wstate_d = W_IDLE;
               bvalid_d = 1'b0;
            end else begin
               wstate_d = W_RESP;
            end
         end
         default: begin
            wstate_d = W_IDLE;
            bvalid_d = 1'b0;
         end
      endcase
      awready_d = (wstate_d == W_IDLE) || (wstate_d == W_GOT_D);
      wready_d  = (wstate_d == W_IDLE) || (wstate_d == W_GOT_A);
   end

   // Read channel next-state: the word is sampled on the AR handshake, before any same-edge commit.
   always_comb begin
      rstate_d = rstate_q;
      rcnt_d   = rcnt_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      case (rstate_q)
         R_IDLE: begin
            if (ar_hs_s) begin
               rdata_d = ar_ok_s ? mem[ar_idx_s] : {DATA_WIDTH{1'b0}};
               rresp_d = ar_ok_s ? RESP_OKAY : RESP_SLVERR;
               if (READ_LATENCY <= 1) begin
                  rstate_d = R_RESP;
               end else begin
                  rstate_d = R_WAIT;
                  rcnt_d   = 3'(READ_LATENCY - 1);
               end
            end else begin
               rstate_d = R_IDLE;
            end
         end
         R_WAIT: begin
            rcnt_d = rcnt_q - 3'd1;
            if (rcnt_q <= 3'd1) begin
               rstate_d = R_RESP;
            end else begin
               rstate_d = R_WAIT;
            end
         end
         R_RESP: begin
            if (r_hs_s) begin
               rstate_d = R_IDLE;
            end else begin
               rstate_d = R_RESP;
            end
         end
         default: begin
            rstate_d = R_IDLE;
         end
      endcase
      arready_d = (rstate_d == R_IDLE);
      rvalid_d  = (rstate_d == R_RESP);
   end

   // State and registered outputs; reset clears every output and aborts any transfer.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wstate_q  <= W_IDLE;
         awaddr_q  <= {ADDR_WIDTH{1'b0}};
         wdata_q   <= {DATA_WIDTH{1'b0}};
         wstrb_q   <= {STRB_WIDTH{1'b0}};
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rstate_q  <= R_IDLE;
         rcnt_q    <= 3'd0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= {DATA_WIDTH{1'b0}};
         rresp_q   <= RESP_OKAY;
      end else begin
         wstate_q  <= wstate_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rstate_q  <= rstate_d;
         rcnt_q    <= rcnt_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   // Byte-masked commit into the array, which itself carries no reset.
   always_ff @(posedge aclk) begin
      if ((wstate_q == W_COMMIT) && aw_ok_s) begin
         for (int i = 0; i < STRB_WIDTH; i++) begin
            if (wstrb_q[i]) begin
               mem[aw_idx_s][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;

endmodule
